// File: rtl/a2d_scan.sv
// a2d_scan: pipelined multi-slot A2D scanner that sequences conversions through a 16-bit SPI master.
// Optional per-slot averaging over 2^AVG_LOG2 scans is built when A2D_AVG_EN is defined.
module a2d_scan #(
    parameter int unsigned NUM_CH   = 3,
    parameter logic [23:0] CH_MAP   = 24'h000160,
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     nxt,
    input  logic                     cont,
    output logic                     busy,
    output logic                     wrt,
    output logic [15:0]              cmd,
    input  logic                     done,
    input  logic [15:0]              rd_data,
    output logic [NUM_CH*DATA_W-1:0] result,
    output logic [NUM_CH-1:0]        ch_upd,
    output logic                     scan_done
);

    typedef enum logic [1:0] {StIdle, StSend, StWait, StGap} state_e;

    localparam logic [3:0] LastK = 4'(NUM_CH);

    state_e                   state_q, state_d;
    logic [3:0]               k_q, k_d;
    logic                     busy_q, busy_d;
    logic                     wrt_q, wrt_d;
    logic                     scan_done_q, scan_done_d;
    logic [15:0]              cmd_q, cmd_d;
    logic [NUM_CH*DATA_W-1:0] result_q, result_d;
    logic [NUM_CH-1:0]        ch_upd_q, ch_upd_d;

    logic [DATA_W-1:0] sample;
    logic [2:0]        cap_slot;
    logic              cap_en;
    logic              win_last;
    logic              unused_rd;

    assign sample    = rd_data[DATA_W-1:0];
    assign unused_rd = ^rd_data;
    // Readback of transaction k belongs to the slot commanded in transaction k-1.
    assign cap_slot  = 3'(k_q - 4'd1);

    function automatic logic [15:0] slot_cmd(input logic [3:0] kk);
        logic [2:0] slot;
        logic [2:0] ch;
        slot = (kk < LastK) ? kk[2:0] : 3'd0;
        ch   = CH_MAP[3*slot +: 3];
        return {2'b00, ch, 11'h000};
    endfunction

`ifdef A2D_AVG_EN
    localparam int unsigned     AccW    = DATA_W + AVG_LOG2;
    localparam int unsigned     CntW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((1 << AVG_LOG2) - 1);

    logic [AccW-1:0] acc_q [NUM_CH];
    logic [AccW-1:0] acc_d [NUM_CH];
    logic [AccW-1:0] acc_sum;
    logic [CntW-1:0] cnt_q, cnt_d;

    assign win_last = (cnt_q == CntLast);
`else
    assign win_last = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        busy_d      = busy_q;
        wrt_d       = 1'b0;
        cmd_d       = cmd_q;
        result_d    = result_q;
        ch_upd_d    = '0;
        scan_done_d = 1'b0;
        cap_en      = 1'b0;
`ifdef A2D_AVG_EN
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        acc_sum     = '0;
`endif
        unique case (state_q)
            StIdle: begin
                if (nxt || cont) begin
                    state_d = StSend;
                    k_d     = 4'd0;
                    busy_d  = 1'b1;
                    wrt_d   = 1'b1;
                    cmd_d   = slot_cmd(4'd0);
                end
            end
            StSend: state_d = StWait;
            StWait: begin
                if (done) begin
                    state_d     = StGap;
                    cap_en      = (k_q != 4'd0);
                    scan_done_d = (k_q == LastK) && win_last;
                end
            end
            StGap: begin
                if (k_q != LastK) begin
                    k_d     = k_q + 4'd1;
                    state_d = StSend;
                    wrt_d   = 1'b1;
                    cmd_d   = slot_cmd(k_q + 4'd1);
                end else begin
                    k_d = 4'd0;
`ifdef A2D_AVG_EN
                    cnt_d = win_last ? '0 : cnt_q + 1'b1;
`endif
                    if (cont) begin
                        state_d = StSend;
                        wrt_d   = 1'b1;
                        cmd_d   = slot_cmd(4'd0);
                    end else begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        for (int i = 0; i < NUM_CH; i++) begin
            if (cap_en && (cap_slot == 3'(i))) begin
`ifdef A2D_AVG_EN
                acc_sum = acc_q[i] + AccW'(sample);
                if (win_last) begin
                    result_d[i*DATA_W +: DATA_W] = DATA_W'(acc_sum >> AVG_LOG2);
                    acc_d[i]                     = '0;
                    ch_upd_d[i]                  = 1'b1;
                end else begin
                    acc_d[i] = acc_sum;
                end
`else
                result_d[i*DATA_W +: DATA_W] = sample;
                ch_upd_d[i]                  = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            k_q         <= 4'd0;
            busy_q      <= 1'b0;
            wrt_q       <= 1'b0;
            cmd_q       <= 16'h0000;
            result_q    <= '0;
            ch_upd_q    <= '0;
            scan_done_q <= 1'b0;
`ifdef A2D_AVG_EN
            acc_q       <= '{default: '0};
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            busy_q      <= busy_d;
            wrt_q       <= wrt_d;
            cmd_q       <= cmd_d;
            result_q    <= result_d;
            ch_upd_q    <= ch_upd_d;
            scan_done_q <= scan_done_d;
`ifdef A2D_AVG_EN
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign wrt       = wrt_q;
    assign cmd       = cmd_q;
    assign result    = result_q;
    assign ch_upd    = ch_upd_q;
    assign scan_done = scan_done_q;

endmodule

// File: tb/tb_a2d_scan.sv
// Self-checking bench for a2d_scan: default 3-slot instance with an SPI responder and a
// scan-level reference model, plus an 8-slot instance driven by hand.
module tb_a2d_scan;
    localparam int NumCh   = 3;
    localparam int DataW   = 12;
    localparam int AvgLog2 = 2;
`ifdef A2D_AVG_EN
    localparam bit AvgEn = 1'b1;
`else
    localparam bit AvgEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic nxt = 1'b0;
    logic cont = 1'b0;
    logic busy, wrt, done, scan_done;
    logic [15:0] cmd, rd_data;
    logic [NumCh*DataW-1:0] result;
    logic [NumCh-1:0] ch_upd;

    logic nxt8 = 1'b0;
    logic done8 = 1'b0;
    logic [15:0] rd8 = 16'h0000;
    logic busy8, wrt8, scan_done8;
    logic [15:0] cmd8;
    logic [8*DataW-1:0] result8;
    logic [7:0] ch_upd8;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    a2d_scan u_dut (
        .clk(clk), .rst(rst), .nxt(nxt), .cont(cont), .busy(busy), .wrt(wrt), .cmd(cmd),
        .done(done), .rd_data(rd_data), .result(result), .ch_upd(ch_upd), .scan_done(scan_done)
    );

    a2d_scan #(.NUM_CH(8), .CH_MAP(24'hFAC688), .DATA_W(DataW), .AVG_LOG2(0)) u_dut8 (
        .clk(clk), .rst(rst), .nxt(nxt8), .cont(1'b0), .busy(busy8), .wrt(wrt8), .cmd(cmd8),
        .done(done8), .rd_data(rd8), .result(result8), .ch_upd(ch_upd8),
        .scan_done(scan_done8)
    );

    // SPI responder: returns queued data lat cycles after each wrt, or a hand-driven done.
    logic        spi_en = 1'b1;
    int          lat = 1;
    logic        spi_done = 1'b0;
    logic [15:0] spi_data = 16'h0000;
    logic        man_done = 1'b0;
    logic [15:0] man_data = 16'h0000;
    logic [15:0] rsp_q[$];

    assign done    = spi_done | man_done;
    assign rd_data = man_done ? man_data : spi_data;

    initial begin
        forever begin
            @(negedge clk);
            if (wrt && spi_en) begin
                repeat (lat) @(negedge clk);
                spi_done = 1'b1;
                spi_data = (rsp_q.size() > 0) ? rsp_q.pop_front() : 16'($urandom);
                @(negedge clk);
                spi_done = 1'b0;
                spi_data = 16'($urandom);
            end
        end
    end

    // Monitor: counts since the last reset.
    int          wrt_cnt = 0;
    int          sd_cnt = 0;
    int          misalign = 0;
    int          upd_cnt[NumCh];
    logic [15:0] cmd_log[$];

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                wrt_cnt = 0; sd_cnt = 0; misalign = 0;
                for (int s = 0; s < NumCh; s++) upd_cnt[s] = 0;
                cmd_log.delete();
            end else begin
                if (wrt) begin wrt_cnt++; cmd_log.push_back(cmd); end
                if (scan_done) begin
                    sd_cnt++;
                    if (!ch_upd[NumCh-1]) misalign++;
                end
                for (int s = 0; s < NumCh; s++) if (ch_upd[s]) upd_cnt[s]++;
            end
        end
    end

    // Reference model: one call per full scan of NumCh+1 readbacks.
    logic [15:0]      scan_d[NumCh+1];
    int unsigned      m_acc[NumCh];
    logic [DataW-1:0] m_res[NumCh];
    int               m_upd[NumCh];
    int               m_sd;
    int               m_win;

    task automatic model_reset();
        for (int s = 0; s < NumCh; s++) begin m_acc[s] = 0; m_res[s] = '0; m_upd[s] = 0; end
        m_sd = 0; m_win = 0;
    endtask

    task automatic queue_scan();
        bit fire;
        int unsigned v;
        for (int k = 0; k <= NumCh; k++) rsp_q.push_back(scan_d[k]);
        fire = !AvgEn || (m_win == (1 << AvgLog2) - 1);
        for (int s = 0; s < NumCh; s++) begin
            v = int'(scan_d[s+1]) % (1 << DataW);
            if (AvgEn) begin
                m_acc[s] += v;
                if (fire) begin m_res[s] = DataW'(m_acc[s] / (1 << AvgLog2)); m_acc[s] = 0; end
            end else begin
                m_res[s] = DataW'(v);
            end
            if (fire) m_upd[s]++;
        end
        if (fire) m_sd++;
        if (AvgEn) m_win = fire ? 0 : m_win + 1;
    endtask

    function automatic logic [NumCh*DataW-1:0] exp_result();
        logic [NumCh*DataW-1:0] v;
        for (int s = 0; s < NumCh; s++) v[s*DataW +: DataW] = m_res[s];
        return v;
    endfunction

    task automatic pulse_nxt();
        @(negedge clk) nxt = 1'b1;
        @(negedge clk) nxt = 1'b0;
    endtask

    task automatic wait_idle(output int cyc, output bit ok);
        cyc = 0; ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!busy) begin ok = 1'b1; break; end
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (wrt !== 1'b0) begin bad++; $display("FAIL rst_wrt got=%b exp=0", wrt); end
        total++; if (cmd !== 16'h0000) begin bad++; $display("FAIL rst_cmd got=%h exp=0000", cmd); end
        total++; if (result !== '0) begin bad++; $display("FAIL rst_result got=%h exp=0", result); end
        total++; if (ch_upd !== '0 || scan_done !== 1'b0) begin
            bad++; $display("FAIL rst_strobes got=%b/%b exp=0/0", ch_upd, scan_done);
        end
        total++; if (busy8 !== 1'b0 || cmd8 !== 16'h0000 || result8 !== '0) begin
            bad++; $display("FAIL rst_dut8 got=%b/%h/%h exp=zero", busy8, cmd8, result8);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        int cyc; bit ok;
        logic [15:0] exp_cmd[4];
        exp_cmd = '{16'h0000, 16'h2000, 16'h2800, 16'h0000};
        lat = 2;
        scan_d = '{16'h0ABC, 16'h0123, 16'h0456, 16'h0789};
        queue_scan();
        pulse_nxt();
        total++; if (wrt !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL start_latency got wrt=%b busy=%b exp=1/1", wrt, busy);
        end
        wait_idle(cyc, ok);
        total++; if (!ok) begin bad++; $display("FAIL dir_timeout got=busy exp=idle"); end
        total++; if (cyc !== 4 * (lat + 2)) begin
            bad++; $display("FAIL dir_scan_len got=%0d exp=%0d", cyc, 4 * (lat + 2));
        end
        @(negedge clk);
        total++; if (cmd_log.size() !== 4) begin
            bad++; $display("FAIL dir_tx_count got=%0d exp=4", cmd_log.size());
        end
        for (int k = 0; k < 4 && k < cmd_log.size(); k++) begin
            total++; if (cmd_log[k] !== exp_cmd[k]) begin
                bad++; $display("FAIL dir_cmd%0d got=%h exp=%h", k, cmd_log[k], exp_cmd[k]);
            end
        end
        total++; if (result !== exp_result()) begin
            bad++; $display("FAIL dir_result got=%h exp=%h", result, exp_result());
        end
        total++; if (sd_cnt !== m_sd || misalign !== 0) begin
            bad++; $display("FAIL dir_scan_done got=%0d/%0d exp=%0d/0", sd_cnt, misalign, m_sd);
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL dir_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_eight();
        logic [15:0] d8[9];
        logic [15:0] ec;
        logic [7:0]  eu;
        int waited; bit ok;
        for (int k = 0; k < 9; k++) d8[k] = 16'($urandom);
        @(negedge clk) nxt8 = 1'b1;
        @(negedge clk) nxt8 = 1'b0;
        for (int t = 0; t <= 8; t++) begin
            ok = 1'b0; waited = 0;
            for (int i = 0; i < 50; i++) begin
                if (wrt8) begin ok = 1'b1; waited = i; break; end
                @(negedge clk);
            end
            total++; if (!ok) begin bad++; $display("FAIL ch8_wrt%0d got=none exp=wrt", t); end
            if (t > 0) begin
                total++; if (waited !== 1) begin
                    bad++; $display("FAIL ch8_gap%0d got=%0d exp=1", t, waited);
                end
            end
            ec = (t < 8) ? 16'(t << 11) : 16'h0000;
            total++; if (cmd8 !== ec) begin
                bad++; $display("FAIL ch8_cmd%0d got=%h exp=%h", t, cmd8, ec);
            end
            @(negedge clk); done8 = 1'b1; rd8 = d8[t];
            @(negedge clk); done8 = 1'b0; rd8 = 16'($urandom);
            eu = (t == 0) ? 8'h00 : 8'(1 << (t - 1));
            total++; if (ch_upd8 !== eu || scan_done8 !== (t == 8)) begin
                bad++; $display("FAIL ch8_upd%0d got=%h/%b exp=%h/%b", t, ch_upd8, scan_done8,
                                eu, (t == 8));
            end
            if (t > 0) begin
                total++; if (result8[(t-1)*DataW +: DataW] !== d8[t][DataW-1:0]) begin
                    bad++; $display("FAIL ch8_res%0d got=%h exp=%h", t - 1,
                                    result8[(t-1)*DataW +: DataW], d8[t][DataW-1:0]);
                end
            end
        end
        @(negedge clk);
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL ch8_busy got=%b exp=0", busy8); end
    endtask

    task automatic test_cont();
        int cyc, base; bit ok;
        lat = 1 + int'($urandom_range(2));
        for (int sc = 0; sc < 4; sc++) begin
            for (int k = 0; k <= NumCh; k++) scan_d[k] = 16'($urandom);
            queue_scan();
        end
        base = wrt_cnt;
        @(negedge clk) cont = 1'b1;
        @(negedge clk);
        cyc = 0; ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (wrt_cnt - base >= 3 * (NumCh + 1) + 2) cont = 1'b0;
            if (!busy) begin ok = 1'b1; break; end
            cyc++;
            @(negedge clk);
        end
        cont = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL cont_timeout got=busy exp=idle"); end
        total++; if (cyc !== 4 * (NumCh + 1) * (lat + 2)) begin
            bad++; $display("FAIL cont_len got=%0d exp=%0d", cyc, 4 * (NumCh + 1) * (lat + 2));
        end
        repeat (3) @(negedge clk);
        total++; if (wrt_cnt - base !== 4 * (NumCh + 1) || busy !== 1'b0) begin
            bad++; $display("FAIL cont_tx got=%0d busy=%b exp=%0d busy=0", wrt_cnt - base, busy,
                            4 * (NumCh + 1));
        end
        total++; if (result !== exp_result()) begin
            bad++; $display("FAIL cont_result got=%h exp=%h", result, exp_result());
        end
        total++; if (sd_cnt !== m_sd || misalign !== 0) begin
            bad++; $display("FAIL cont_scan_done got=%0d/%0d exp=%0d/0", sd_cnt, misalign, m_sd);
        end
        for (int s = 0; s < NumCh; s++) begin
            total++; if (upd_cnt[s] !== m_upd[s]) begin
                bad++; $display("FAIL cont_upd%0d got=%0d exp=%0d", s, upd_cnt[s], m_upd[s]);
            end
        end
    endtask

    task automatic test_ignored();
        int cyc, base; bit ok;
        base = wrt_cnt;
        @(negedge clk) begin man_data = 16'h0FFF; man_done = 1'b1; end
        @(negedge clk) man_done = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0 || wrt_cnt !== base) begin
            bad++; $display("FAIL idle_done got=busy%b tx%0d exp=busy0 tx%0d", busy, wrt_cnt, base);
        end
        total++; if (result !== exp_result() || sd_cnt !== m_sd) begin
            bad++; $display("FAIL idle_done_res got=%h exp=%h", result, exp_result());
        end
        lat = 4;
        for (int k = 0; k <= NumCh; k++) scan_d[k] = 16'($urandom);
        queue_scan();
        pulse_nxt();
        @(negedge clk) nxt = 1'b1;
        @(negedge clk) nxt = 1'b0;
        wait_idle(cyc, ok);
        repeat (5) @(negedge clk);
        total++; if (!ok || busy !== 1'b0 || wrt_cnt - base !== NumCh + 1) begin
            bad++; $display("FAIL wait_nxt got=tx%0d busy%b exp=tx%0d busy0", wrt_cnt - base, busy,
                            NumCh + 1);
        end
        total++; if (result !== exp_result()) begin
            bad++; $display("FAIL wait_nxt_res got=%h exp=%h", result, exp_result());
        end
        lat = 1;
        for (int k = 0; k <= NumCh; k++) scan_d[k] = 16'hFFFF;
        queue_scan();
        pulse_nxt();
        wait_idle(cyc, ok);
        @(negedge clk);
        total++; if (!ok || result !== exp_result()) begin
            bad++; $display("FAIL ffff_mask got=%h exp=%h", result, exp_result());
        end
    endtask

    task automatic man_tx(input logic [15:0] d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (wrt) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk); man_data = d; man_done = 1'b1;
        @(negedge clk); man_done = 1'b0;
    endtask

    task automatic test_rst_mid();
        int cyc; bit ok, ok1;
        spi_en = 1'b0;
        pulse_nxt();
        man_tx(16'h0111, ok);
        man_tx(16'h0222, ok1);
        ok = ok & ok1;
        for (int i = 0; i < 50; i++) begin
            if (wrt) break;
            @(negedge clk);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (!ok || busy !== 1'b0 || wrt !== 1'b0 || cmd !== 16'h0000) begin
            bad++; $display("FAIL midrst_ctrl got=%b/%b/%h exp=0/0/0000", busy, wrt, cmd);
        end
        total++; if (result !== '0 || ch_upd !== '0 || scan_done !== 1'b0) begin
            bad++; $display("FAIL midrst_data got=%h/%b/%b exp=0", result, ch_upd, scan_done);
        end
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        model_reset();
        man_data = 16'h0333; man_done = 1'b1;
        @(negedge clk) man_done = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0 || result !== '0 || wrt_cnt !== 0) begin
            bad++; $display("FAIL late_done got=busy%b res%h tx%0d exp=0", busy, result, wrt_cnt);
        end
        spi_en = 1'b1;
        lat = 1;
        for (int k = 0; k <= NumCh; k++) scan_d[k] = 16'($urandom);
        queue_scan();
        pulse_nxt();
        wait_idle(cyc, ok);
        @(negedge clk);
        total++; if (!ok || cmd_log.size() !== NumCh + 1) begin
            bad++; $display("FAIL post_rst_tx got=%0d exp=%0d", cmd_log.size(), NumCh + 1);
        end else begin
            total++; if (cmd_log[0] !== 16'h0000) begin
                bad++; $display("FAIL post_rst_k0 got=%h exp=0000", cmd_log[0]);
            end
        end
        total++; if (result !== exp_result()) begin
            bad++; $display("FAIL post_rst_res got=%h exp=%h", result, exp_result());
        end
    endtask

    task automatic test_avg();
        int cyc; bit ok;
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        model_reset();
        lat = 1;
        for (int sc = 0; sc < 4; sc++) begin
            for (int k = 0; k <= NumCh; k++) scan_d[k] = 16'($urandom);
            scan_d[1] = 16'(100 + sc);
            queue_scan();
            pulse_nxt();
            wait_idle(cyc, ok);
            @(negedge clk);
            total++; if (!ok || result[DataW-1:0] !== m_res[0]) begin
                bad++; $display("FAIL avg_slot0_scan%0d got=%0d exp=%0d", sc, result[DataW-1:0],
                                m_res[0]);
            end
            total++; if (upd_cnt[0] !== m_upd[0] || sd_cnt !== m_sd) begin
                bad++; $display("FAIL avg_upd_scan%0d got=%0d/%0d exp=%0d/%0d", sc, upd_cnt[0],
                                sd_cnt, m_upd[0], m_sd);
            end
        end
        total++; if (result !== exp_result()) begin
            bad++; $display("FAIL avg_result got=%h exp=%h", result, exp_result());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_eight();
        test_cont();
        test_ignored();
        test_rst_mid();
        test_avg();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/a2d_scan.md
# a2d_scan

Parametrised, pipelined multi-channel A2D scanner that sequences conversions through the existing 16-bit SPI master (wrt/done/cmd/rd_data handshake) and keeps one result register per channel slot. It is the next generation of the three-channel load-cell/battery interface. It scales to 1–8 slots with a configurable channel map, overlaps each command with the previous channel's readback, and adds continuous-scan mode. It sits between the SPI master and the balance/battery logic.

## Interface
- NUM_CH, 3, number of scanned slots, legal 1..8
- CH_MAP, 24'h000160, 3-bit ADC channel per slot; slot i at bits [3i+2:3i]; default maps slots 0/1/2 to ch0/ch4/ch5
- DATA_W, 12, result width, legal 1..16
- AVG_LOG2, 2, log2 of averaging depth; used only with A2D_AVG_EN

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- nxt  in  1  request one scan; sampled in IDLE only
- cont  in  1  continuous mode; while high, scans restart back-to-back
- busy  out  1  high whenever FSM is not IDLE
- wrt  out  1  one-cycle start pulse to SPI master
- cmd  out  16  SPI command = {2'b00, ch[2:0], 11'h000}
- done  in  1  SPI master transaction-complete pulse
- rd_data  in  16  SPI read data, valid in the done cycle
- result  out  NUM_CH*DATA_W  slot i at [i*DATA_W +: DATA_W]
- ch_upd  out  NUM_CH  one-cycle strobe, bit i when slot i result changes
- scan_done  out  1  one-cycle strobe when a full result set is written

## Operation
- The ADC returns the conversion for the command sent in the previous transaction. A scan is therefore NUM_CH+1 transactions, k = 0..NUM_CH.
- Transaction k sends the CH_MAP slot k command for k < NUM_CH. The final dummy (k = NUM_CH) resends slot 0.
- On done of transaction k ≥ 1, rd_data[DATA_W-1:0] is captured into slot k-1. The done of k = 0 is discarded.
- FSM states:
  - IDLE: nxt or cont → SEND, k = 0.
  - SEND: wrt = 1 for exactly one cycle → WAIT.
  - WAIT: hold until done → GAP.
  - GAP: one idle cycle. If k < NUM_CH: k++, → SEND. If k == NUM_CH: pulse scan_done; if cont → SEND with k = 0, else → IDLE.
- cmd is registered. It changes only on entry to SEND and is stable until the next SEND.
- Ignored inputs:
  - nxt outside IDLE.
  - done outside WAIT.
  - rd_data bits above DATA_W-1.
- cont falling mid-scan: the current scan completes, then the FSM goes to IDLE.
- NUM_CH = 1: two transactions per scan, both commanding CH_MAP slot 0.

## Timing
- Reset values: state IDLE, k = 0, busy = 0, wrt = 0, cmd = 16'h0000, result all zero, ch_upd = 0, scan_done = 0.
- nxt high at edge n → SEND during cycle n+1, with wrt high that cycle.
- done at edge d:
  - result slot and ch_upd bit update at edge d+1 (visible the cycle after done).
  - Next wrt at cycle d+2, after the GAP cycle.
- scan_done is asserted in the same cycle as the last ch_upd bit.
- Scan length: (NUM_CH+1) × (T_spi + 2) cycles, where T_spi = wrt-to-done cycles.
- busy rises the cycle after nxt is accepted and falls the cycle after GAP exits to IDLE.
- Reset asserted mid-transaction returns to reset values immediately. A later stray done is ignored (the FSM is not in WAIT).

## Configuration
- Macro A2D_AVG_EN.
- Defined:
  - Each slot has a (DATA_W+AVG_LOG2)-bit accumulator, and a shared scan counter counts 0..2^AVG_LOG2-1.
  - Captures add into the accumulator.
  - On the last scan of a window, result slot = accumulator >> AVG_LOG2 (truncating) and the accumulator is cleared.
  - ch_upd and scan_done pulse only in that window's final scan.
  - Reset clears the accumulators and the counter.
- Undefined: no accumulators exist, each capture is written directly, and ch_upd/scan_done pulse every scan.

## Test plan
- Default params, nxt pulse, SPI model returns 16'h0ABC, 16'h0123, 16'h0456, 16'h0789 on four transactions:
  - cmd sequence 0000, 2000, 2800, 0000.
  - result = {12'h789, 12'h456, 12'h123}; slot 0 ignores 0ABC.
  - scan_done is a single pulse; busy drops afterwards.
- NUM_CH = 8, CH_MAP = 24'hFAC688 (slots 0..7 → ch0..ch7):
  - cmds 0000, 0800 … 3800, 0000.
  - ch_upd bits 0..7 fire in order, one per transaction.
- cont held high for 3 scans, then dropped in mid-scan:
  - 3 scan_done pulses, no gap beyond GAP between scans.
  - 4th scan completes, then IDLE.
- Ignored stimulus:
  - nxt pulsed during WAIT and a spurious done in IDLE: no extra transaction, no result change.
  - rd_data = 16'hFFFF with DATA_W = 12 → slot = 12'hFFF.
- rst pulsed during WAIT of transaction 2, then done arrives:
  - Outputs return to zero immediately.
  - Late done is ignored; a new nxt starts from k = 0.
- With A2D_AVG_EN, AVG_LOG2 = 2, slot 0 samples 100, 101, 102, 103:
  - Result updates only after scan 4, to 101.
  - ch_upd[0] fires once in 4 scans.
